bus_arbiter_rr4: RTL

- Round-robin arbiter/sequencer that shares one 32-bit memory/peripheral port among 4 requesters (e.g. IF, LSU, debug, DMA).
- Its registered 2-bit grant drives the `sel` of the 4:1 32-bit mux instances that steer address and write data onto the shared bus.
- One transaction is outstanding at a time: grant, issue, wait for response, route the response back.
- A watchdog terminates hung transactions.

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/mux4to1.sv | 20 ++
 rtl/mux4to1_32bit.sv | 20 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/bus_arbiter_rr4.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 4-way round-robin bus arbiter.
package bus_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int WDOG_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef logic [1:0]        grant_t;
    typedef logic [WDOG_W-1:0] wdog_t;

endpackage

// File: rtl/mux4to1.sv
// 1-bit 4:1 multiplexer.
module mux4to1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4to1_32bit.sv
// 32-bit 4:1 multiplexer.
module mux4to1_32bit (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    input  logic [1:0]  sel,
    output logic [31:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request in order ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  grant_t           ptr,
    output grant_t           idx,
    output logic             any
);

    grant_t cand;

    // Walk from lowest priority to highest so the highest-priority hit is written last.
    always_comb begin
        idx  = ptr;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + grant_t'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin sequencer sharing one 32-bit bus among 4 requesters, one transaction
// outstanding, with a watchdog that forces an error response on hung transactions.
module bus_arbiter_rr4
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ-1:0][31:0] req_addr,
    input  logic [N_REQ-1:0][31:0] req_wdata,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   bus_valid,
    output logic                   bus_we,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    input  logic                   bus_ready,
    input  logic                   bus_rsp_valid,
    input  logic [31:0]            bus_rdata,
    output logic [1:0]             grant_sel,
    output logic                   busy,
    output logic                   timeout_err
);

    state_t            state_reg, state_next;
    grant_t            ptr_reg, ptr_next;
    grant_t            grant_sel_reg, grant_sel_next;
    wdog_t             wdog_reg, wdog_next;
    logic [N_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              timeout_err_reg, timeout_err_next;

    grant_t            pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  grant_onehot;
    logic              wdog_expired;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_sel_reg == grant_t'(gi));
        end
    endgenerate

    // Watchdog is cleared on accept, so this is the TIMEOUT-th cycle spent in WAIT.
    assign wdog_expired = (wdog_reg == wdog_t'(TIMEOUT - 1));

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_sel_next   = grant_sel_reg;
        wdog_next        = wdog_reg;
        rsp_valid_next   = '0;
        rsp_rdata_next   = rsp_rdata_reg;
        timeout_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_sel_next = pick_idx;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_ready) begin
                    wdog_next  = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                wdog_next = wdog_reg + wdog_t'(1);
                // A real response arriving on the expiry cycle takes precedence.
                if (bus_rsp_valid || wdog_expired) begin
                    rsp_valid_next   = grant_onehot;
                    rsp_rdata_next   = bus_rsp_valid ? bus_rdata : ERR_DATA;
                    timeout_err_next = !bus_rsp_valid;
                    ptr_next         = grant_sel_reg;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= grant_t'(N_REQ - 1);
            grant_sel_reg   <= '0;
            wdog_reg        <= '0;
            rsp_valid_reg   <= '0;
            rsp_rdata_reg   <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_sel_reg   <= grant_sel_next;
            wdog_reg        <= wdog_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    mux4to1_32bit u_addr_mux (
        .d0  (req_addr[0]),
        .d1  (req_addr[1]),
        .d2  (req_addr[2]),
        .d3  (req_addr[3]),
        .sel (grant_sel_reg),
        .y   (bus_addr)
    );

    mux4to1_32bit u_wdata_mux (
        .d0  (req_wdata[0]),
        .d1  (req_wdata[1]),
        .d2  (req_wdata[2]),
        .d3  (req_wdata[3]),
        .sel (grant_sel_reg),
        .y   (bus_wdata)
    );

    mux4to1 u_we_mux (
        .d0  (req_we[0]),
        .d1  (req_we[1]),
        .d2  (req_we[2]),
        .d3  (req_we[3]),
        .sel (grant_sel_reg),
        .y   (bus_we)
    );

    assign bus_valid   = (state_reg == ISSUE);
    assign req_ready   = grant_onehot & {N_REQ{bus_valid && bus_ready}};
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign timeout_err = timeout_err_reg;
    assign grant_sel   = grant_sel_reg;
    assign busy        = (state_reg != IDLE);

endmodule
